// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// It owns the architectural HI/LO registers and raises a pipeline stall
// when an instruction depends on an operation that is still in flight.
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             mf_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             stall
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state, next;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;     // latched op[1]
   logic               neg_q;      // product / quotient must be negated
   logic               neg_r;      // remainder takes a negative dividend's sign
   logic               dz_pend;    // divide-by-zero shortcut pending in RUN
   logic [WIDTH-1:0]   dvs;        // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   acc;        // product high word or partial remainder
   logic [WIDTH-1:0]   low;        // multiplier/product low word or dividend/quotient

   logic               div0;
   logic [WIDTH-1:0]   mag_rs, mag_rt;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               last_iter;

   assign div0      = op[1] && (rt == '0);
   assign mag_rs    = (op[0] && rs[WIDTH-1]) ? -rs : rs;
   assign mag_rt    = (op[0] && rt[WIDTH-1]) ? -rt : rt;
   assign mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, dvs} : '0);
   assign div_sh    = {acc, low[WIDTH-1]};
   assign div_diff  = div_sh - {1'b0, dvs};
   assign prod      = {acc, low};
   assign prod_fix  = neg_q ? -prod : prod;
   assign quo_fix   = neg_q ? -low : low;
   assign rem_fix   = neg_r ? -acc : acc;
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign stall = busy & (start | mf_req | mthi | mtlo);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next;
   end

   // Next-state decode: RUN exits early for divide by zero, else after 32 iterations
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (start) next = RUN;
         RUN:     if (dz_pend) next = DONE;
                  else if (last_iter) next = FIX;
         FIX:     next = DONE;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Operand capture, shift-add / restoring-divide iterations, sign fix-up and HI/LO writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz_pend  <= 1'b0;
         dvs      <= '0;
         acc      <= '0;
         low      <= '0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  cnt      <= '0;
                  acc      <= '0;
                  dvs      <= mag_rt;
                  // the raw dividend is kept for the divide-by-zero HI value
                  low      <= div0 ? rs : mag_rs;
                  neg_q    <= op[0] & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                  neg_r    <= op[0] & rs[WIDTH-1];
                  dz_pend  <= div0;
                  div_zero <= div0;
               end else begin
                  if (mthi) hi <= rs;
                  if (mtlo) lo <= rs;
               end
            end
            RUN: begin
               if (dz_pend) begin
                  hi      <= low;
                  lo      <= '1;
                  dz_pend <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (is_div) begin
                     if (!div_diff[WIDTH]) begin
                        acc <= div_diff[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], 1'b1};
                     end else begin
                        acc <= div_sh[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     acc <= mul_sum[WIDTH:1];
                     low <= {mul_sum[0], low[WIDTH-1:1]};
                  end
               end
            end
            FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an
// arithmetic reference model (64-bit products, native division).
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] rs = '0;
   logic [31:0] rt = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        mf_req = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero, stall;

   int total = 0;
   int passed = 0;
   int failed = 0;

   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
      .mthi(mthi), .mtlo(mtlo), .mf_req(mf_req),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference result {hi, lo} from plain arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'd0: res = {32'd0, a} * {32'd0, b};
         2'd1: res = 64'(sa * sb);
         2'd2: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Present an op in IDLE; returns one clock after the accepting edge
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; rs = a; rt = b; start = 1'b1;
      #1 check("stall_at_accept", stall, 0);
      step();
      start = 1'b0;
   endtask

   // Bounded wait for done; n counts edges after acceptance, stable tracks HI/LO holding
   task automatic wait_done(input logic [31:0] h0, input logic [31:0] l0,
                            output int n, output logic stable);
      n = 1;
      stable = 1'b1;
      while (!done && n < 60) begin
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         step();
         n++;
      end
      n--;
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      logic [63:0] exp;
      logic [31:0] h0, l0;
      int          n;
      logic        st;
      exp = ref_result(o, a, b);
      h0 = hi; l0 = lo;
      issue(o, a, b);
      wait_done(h0, l0, n, st);
      check({tag, "_latency"}, n, (o[1] && b == 0) ? 1 : 33);
      check({tag, "_hold"}, st, 1);
      check({tag, "_hi"}, hi, exp[63:32]);
      check({tag, "_lo"}, lo, exp[31:0]);
      check({tag, "_divzero"}, div_zero, (o[1] && b == 0) ? 1 : 0);
      step();
      check({tag, "_idle"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int          n;
      logic        all_stall, lo_hold, no_done;
      logic [31:0] l0, a, b;
      logic [1:0]  o;

      // Reset state
      mf_req = 1'b1;
      #12;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_divzero", div_zero, 0);
      check("rst_stall", stall, 0);
      mf_req = 1'b0;
      rst_n = 1'b1;
      step();

      // MTHI / MTLO in IDLE
      rs = 32'h1234; mthi = 1'b1;
      step();
      mthi = 1'b0;
      check("mthi", hi, 32'h1234);
      rs = 32'h5678; mtlo = 1'b1;
      step();
      mtlo = 1'b0;
      check("mtlo", lo, 32'h5678);

      // start coincident with mthi: the move is dropped
      op = 2'd0; rs = 32'd2; rt = 32'd3; start = 1'b1; mthi = 1'b1;
      step();
      start = 1'b0; mthi = 1'b0;
      check("start_wins_hi", hi, 32'h1234);
      wait_done(32'h1234, 32'h5678, n, lo_hold);
      check("start_wins_res", {hi, lo}, 64'd6);
      step();

      // Directed arithmetic
      run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mult_neg", 2'd1, -32'sd3, 32'd5);
      run_op("div_neg", 2'd3, -32'sd7, 32'd2);
      run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_zero", 2'd2, 32'd100, 32'd0);
      run_op("multu_clr", 2'd0, 32'd1, 32'd1);
      run_op("div_zero_s", 2'd3, 32'hFFFF_FF00, 32'd0);
      run_op("divu_big", 2'd2, 32'hFFFF_FFFF, 32'd3);

      // mf_req hazard: stalls every cycle through DONE, released in IDLE
      issue(2'd0, 32'h10, 32'h20);
      mf_req = 1'b1;
      all_stall = 1'b1;
      n = 0;
      while (!done && n < 60) begin
         if (stall !== 1'b1) all_stall = 1'b0;
         step();
         n++;
      end
      check("mf_stall_run", all_stall, 1);
      check("mf_stall_done", {done, stall}, 2'b11);
      check("mf_hilo_valid", {hi, lo}, 64'h200);
      step();
      check("mf_stall_idle", {busy, stall}, 2'b00);
      mf_req = 1'b0;

      // Back-to-back: second start re-presented while busy, accepted one cycle after DONE
      op = 2'd0; rs = 32'd5; rt = 32'd6; start = 1'b1;
      step();
      op = 2'd3; rs = -32'sd100; rt = 32'd7;
      all_stall = 1'b1;
      n = 0;
      while (!done && n < 60) begin
         if (stall !== 1'b1) all_stall = 1'b0;
         step();
         n++;
      end
      check("b2b_stall", {all_stall, stall}, 2'b11);
      check("b2b_first", {hi, lo}, 64'd30);
      step();
      check("b2b_idle", {busy, stall}, 2'b00);
      step();
      check("b2b_accept", busy, 1);
      start = 1'b0;
      wait_done(32'd0, 32'd30, n, lo_hold);
      check("b2b_second_lat", n, 33);
      check("b2b_second", {hi, lo}, ref_result(2'd3, -32'sd100, 32'd7));
      step();

      // MTLO during RUN: stalls, LO untouched until completion, move lands in IDLE
      issue(2'd0, 32'h10, 32'h20);
      l0 = lo;
      mtlo = 1'b1; rs = 32'hDEAD;
      all_stall = 1'b1;
      lo_hold = 1'b1;
      n = 0;
      while (!done && n < 60) begin
         if (stall !== 1'b1) all_stall = 1'b0;
         if (lo !== l0) lo_hold = 1'b0;
         step();
         n++;
      end
      check("mtlo_run_stall", all_stall, 1);
      check("mtlo_run_hold", lo_hold, 1);
      check("mtlo_run_result", lo, 32'h200);
      step();
      check("mtlo_idle_stall", stall, 0);
      step();
      mtlo = 1'b0;
      check("mtlo_after", lo, 32'hDEAD);

      // Randomized operations
      for (int i = 0; i < 16; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 50));
            3:       b = -32'($urandom_range(1, 50));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = -32'($urandom_range(0, 1000));
         run_op("rand", o, a, b);
      end

      // Reset mid-RUN discards the operation
      rs = 32'hAAAA; mthi = 1'b1;
      step();
      mthi = 1'b0;
      issue(2'd0, 32'd7, 32'd9);
      for (int i = 0; i < 9; i++) step();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_state", {busy, done, div_zero}, 3'b000);
      no_done = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 3) rst_n = 1'b1;
         if (done !== 1'b0) no_done = 1'b0;
         step();
      end
      check("midrst_no_done", no_done, 1);
      check("midrst_hilo_after", {hi, lo}, 64'd0);
      run_op("midrst_fresh", 2'd0, 32'd7, 32'd9);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller for the EX stage. Runs MULT/MULTU/DIV/DIVU as 32-iteration shift-add / restoring-divide sequences and owns the architectural HI/LO registers.
- Generates the pipeline stall for hazards against an in-flight operation: a new mul/div issue, MFHI/MFLO, or MTHI/MTLO.
- Sits beside the EX-stage ALU and takes the same forwarded rs/rt operands.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported.
- CNT_W, 6, iteration-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue request, qualified by EX-stage valid
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs  in  WIDTH  multiplicand / dividend
- rt  in  WIDTH  multiplier / divisor
- mthi  in  1  write rs into HI
- mtlo  in  1  write rs into LO
- mf_req  in  1  EX instruction is MFHI or MFLO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- div_zero  out  1  sticky: last divide had rt==0
- stall  out  1  combinational pipeline freeze request

Behaviour:
- Reset, asynchronous on rst_n=0, effective mid-operation:
  - state=IDLE; hi=lo=0; done=0; div_zero=0; counter=0.
  - Any in-flight result is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge E accepts the operation.
  - Latch the op type. For signed ops, latch |rs|, |rt| and the sign flags; for unsigned ops, latch the raw values.
  - Clear the accumulator and counter. Go to RUN.
- Divide by zero (op[1]=1 and rt==0) at acceptance:
  - Go directly to DONE at edge E+1.
  - hi=rs, lo=32'hFFFF_FFFF, div_zero=1.
- div_zero update: set to 1 when a divide is accepted with rt==0; cleared to 0 when any other operation is accepted.
- RUN, one iteration per edge:
  - Multiply: add the multiplicand if multiplier LSB=1, then shift the 64-bit {acc, mplr} right.
  - Divide: shift {rem, quo} left and trial-subtract the divisor. Keep the result if non-negative and set the quotient bit.
  - Counter increments each edge. After the 32nd iteration (edge E+32) go to FIX.
- FIX (edge E+33):
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient if the signs differ; remainder takes the dividend's sign.
  - Write hi (product high word / remainder) and lo (product low word / quotient). Go to DONE.
- DONE:
  - done=1 for exactly one cycle. Go to IDLE on the next edge.
  - Normal latency: done is high in the cycle after edge E+33; busy is high from E+1 through DONE.
- hi/lo stability: hi/lo hold their old values throughout RUN and change only at FIX or on the divide-by-zero shortcut.
- Signed overflow: 0x8000_0000 / -1 gives lo=32'h8000_0000, hi=0. Magnitude arithmetic uses 33-bit intermediates.
- mthi/mtlo:
  - Take effect at the edge only when state==IDLE and start==0.
  - If start and mthi/mtlo coincide in IDLE, start wins and the move is dropped; the pipeline never issues both.
- stall = busy & (start | mf_req | mthi | mtlo).
  - The pipeline holds the instruction while stall=1, so a start raised during busy is re-presented and accepted in IDLE.
  - stall is low during IDLE, including the cycle a start is accepted.
- start asserted in DONE is not accepted: stall=1 that cycle, accepted the next cycle in IDLE.
- mf_req in DONE stalls; hi/lo are valid from the DONE cycle onward.

Test Plan:
- Reset mid-RUN: MULTU 7×9, deassert rst_n at edge E+10 → hi=lo=0, busy=0, done never pulses; a fresh start is accepted after release.
- MULTU and MULT:
  - MULTU 0xFFFF_FFFF×0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001, done in the cycle after E+33.
  - MULT -3×5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- DIV signs: DIV -7/2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV 0x8000_0000/-1 → lo=0x8000_0000, hi=0.
- Divide by zero: DIVU 100/0 → DONE at E+1, hi=100, lo=0xFFFF_FFFF, div_zero=1. A following MULTU 1×1 clears div_zero.
- Hazard stall:
  - mf_req during RUN → stall=1 every cycle through DONE, 0 in IDLE.
  - Back-to-back start → second op accepted exactly one cycle after DONE.
- MTHI/MTLO:
  - mthi with rs=0x1234 in IDLE → hi=0x1234 next edge.
  - mtlo during RUN → stall=1, lo unchanged until completion overwrites it.
